// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY-side responder with a minimal BMCR/BMSR/ID/ANAR register file.
// Optional feature macro: MDIO_PREAMBLE_SUPPRESS_EN (preamble suppression after the first frame).
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0022,
  parameter logic [15:0] PHY_ID2  = 16'h1560
) (
  input  logic aclk,
  input  logic rst,
  input  logic mdc,
  input  logic mdio_i,
  output logic mdio_o,
  output logic mdio_t,
  input  logic link_up,
  output logic loopback,
  output logic speed_100,
  output logic an_enable,
  output logic full_duplex
);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam logic PRE_SUP = 1'b1;
`else
  localparam logic PRE_SUP = 1'b0;
`endif

  localparam logic [5:0] PRE_FULL = 6'd32;
  // BMCR writable bits packed as {loopback, speed_100, an_enable, full_duplex}
  localparam logic [3:0] CTL_RST  = 4'b0111;
  localparam logic [8:0] ANAR_RST = 9'h00F;

  typedef enum logic [2:0] {
    IDLE, ST1, OP, PHYAD, REGAD, TA, RD_DATA, WR_DATA
  } state_t;

  function automatic logic [5:0] sat_pre(input logic [5:0] c);
    return (c >= PRE_FULL) ? PRE_FULL : c + 6'd1;
  endfunction

  function automatic logic [15:0] reg_rd(input logic [4:0] a, input logic [3:0] ctl,
                                         input logic [8:0] anar, input logic lk);
    logic [15:0] v;
    v = '0;
    case (a)
      5'd0:    v = {1'b0, ctl[3:1], 3'b000, ctl[0], 8'h00};
      5'd1:    v = 16'h7809 | {9'd0, PRE_SUP, 3'd0, lk, 2'd0};
      5'd2:    v = PHY_ID1;
      5'd3:    v = PHY_ID2;
      5'd4:    v = {2'b00, anar, 5'b00001};
      default: v = '0;
    endcase
    return v;
  endfunction

  logic mdc_p0, mdc_p1, mdc_p2, mdio_p0, mdio_p1;
  logic rise, bit_in, match, st_ok;

  state_t      state_q, state_d;
  logic [5:0]  pre_q, pre_d;
  logic [2:0]  fld_q, fld_d;
  logic [3:0]  dat_q, dat_d;
  logic        op0_q, op0_d, op_rd_q, op_rd_d;
  logic [4:0]  phy_q, phy_d, reg_q, reg_d;
  logic [15:0] sh_q, sh_d;
  logic        mdio_o_d, mdio_t_d;
  logic [3:0]  ctl_q, ctl_d;
  logic [8:0]  anar_q, anar_d;
  logic        seen_q, seen_d;

  // Stage p0/p1: two-flop synchronizers; p2: previous mdc for edge detect
  always_ff @(posedge aclk) begin
    mdc_p0  <= mdc;
    mdc_p1  <= mdc_p0;
    mdc_p2  <= mdc_p1;
    mdio_p0 <= mdio_i;
    mdio_p1 <= mdio_p0;
  end

  assign rise   = mdc_p1 & ~mdc_p2;
  assign bit_in = mdio_p1;
  assign match  = (phy_q == PHY_ADDR);
  assign st_ok  = (pre_q == PRE_FULL) || (PRE_SUP && seen_q && (pre_q != 6'd0));

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    fld_d    = fld_q;
    dat_d    = dat_q;
    op0_d    = op0_q;
    op_rd_d  = op_rd_q;
    phy_d    = phy_q;
    reg_d    = reg_q;
    sh_d     = sh_q;
    mdio_o_d = mdio_o;
    mdio_t_d = mdio_t;
    ctl_d    = ctl_q;
    anar_d   = anar_q;
    seen_d   = seen_q;
    if (rise) begin
      case (state_q)
        IDLE: begin
          if (bit_in) begin
            pre_d = sat_pre(pre_q);
          end else if (st_ok) begin
            state_d = ST1;
            pre_d   = '0;
          end else begin
            pre_d = '0;
          end
        end
        ST1: begin
          fld_d   = '0;
          state_d = bit_in ? OP : IDLE;
        end
        OP: begin
          if (fld_q == 3'd0) begin
            op0_d = bit_in;
            fld_d = 3'd1;
          end else if (op0_q != bit_in) begin
            op_rd_d = op0_q;
            fld_d   = '0;
            state_d = PHYAD;
          end else begin
            state_d = IDLE;
          end
        end
        PHYAD: begin
          phy_d = {phy_q[3:0], bit_in};
          fld_d = fld_q + 3'd1;
          if (fld_q == 3'd4) begin
            fld_d   = '0;
            state_d = REGAD;
          end
        end
        REGAD: begin
          reg_d = {reg_q[3:0], bit_in};
          fld_d = fld_q + 3'd1;
          if (fld_q == 3'd4) begin
            // snapshot read data now so later link_up changes do not tear the frame
            sh_d    = reg_rd({reg_q[3:0], bit_in}, ctl_q, anar_q, link_up);
            fld_d   = '0;
            state_d = TA;
          end
        end
        TA: begin
          if (fld_q == 3'd0) begin
            fld_d = 3'd1;
            if (op_rd_q && match) begin
              mdio_t_d = 1'b0;
              mdio_o_d = 1'b0;
            end
          end else begin
            dat_d   = '0;
            state_d = op_rd_q ? RD_DATA : WR_DATA;
            if (op_rd_q && match) begin
              mdio_o_d = sh_q[15];
              sh_d     = {sh_q[14:0], 1'b0};
            end
          end
        end
        RD_DATA: begin
          dat_d = dat_q + 4'd1;
          if (dat_q == 4'd15) begin
            mdio_t_d = 1'b1;
            mdio_o_d = 1'b0;
            pre_d    = '0;
            seen_d   = 1'b1;
            state_d  = IDLE;
          end else if (match) begin
            mdio_o_d = sh_q[15];
            sh_d     = {sh_q[14:0], 1'b0};
          end
        end
        WR_DATA: begin
          sh_d  = {sh_q[14:0], bit_in};
          dat_d = dat_q + 4'd1;
          if (dat_q == 4'd15) begin
            pre_d   = '0;
            seen_d  = 1'b1;
            state_d = IDLE;
            // sh_q[14:0] holds D15..D1 here, so data bit k sits at sh_q[k-1]
            if (match) begin
              case (reg_q)
                5'd0: ctl_d = sh_q[14] ? CTL_RST : {sh_q[13:11], sh_q[7]};
                5'd4: anar_d = sh_q[12:4];
                default: ;
              endcase
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    op0_q <= op0_d;
    phy_q <= phy_d;
    reg_q <= reg_d;
    sh_q  <= sh_d;
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      fld_q   <= '0;
      dat_q   <= '0;
      op_rd_q <= 1'b0;
      mdio_o  <= 1'b0;
      mdio_t  <= 1'b1;
      ctl_q   <= CTL_RST;
      anar_q  <= ANAR_RST;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      fld_q   <= fld_d;
      dat_q   <= dat_d;
      op_rd_q <= op_rd_d;
      mdio_o  <= mdio_o_d;
      mdio_t  <= mdio_t_d;
      ctl_q   <= ctl_d;
      anar_q  <= anar_d;
      seen_q  <= seen_d;
    end
  end

  assign loopback    = ctl_q[3];
  assign speed_100   = ctl_q[2];
  assign an_enable   = ctl_q[1];
  assign full_duplex = ctl_q[0];

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Scoreboard bench for mdio_phy_responder: a bench-side MAC issues frames, a
// register-level model predicts every MDC-rise line state, a monitor compares.
module tb_mdio_phy_responder;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam logic SUP = 1'b1;
`else
  localparam logic SUP = 1'b0;
`endif

  logic aclk    = 1'b0;
  logic rst     = 1'b1;
  logic mdc     = 1'b0;
  logic mac_oe  = 1'b1;
  logic mac_val = 1'b1;
  logic link_up = 1'b0;
  logic mdio_i, mdio_o, mdio_t, loopback, speed_100, an_enable, full_duplex;
  int   total = 0;
  int   bad   = 0;

  // Line resolution: PHY drive wins, else MAC drive, else pull-up
  assign mdio_i = (mdio_t === 1'b0) ? mdio_o : (mac_oe ? mac_val : 1'b1);

  mdio_phy_responder dut (
    .aclk        (aclk),
    .rst         (rst),
    .mdc         (mdc),
    .mdio_i      (mdio_i),
    .mdio_o      (mdio_o),
    .mdio_t      (mdio_t),
    .link_up     (link_up),
    .loopback    (loopback),
    .speed_100   (speed_100),
    .an_enable   (an_enable),
    .full_duplex (full_duplex)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Register-level reference model
  logic [15:0] m_bmcr, m_anar;
  logic        m_seen;

  task automatic m_reset();
    m_bmcr = 16'h3100;
    m_anar = 16'h01E1;
    m_seen = 1'b0;
  endtask

  function automatic logic [15:0] m_read(input logic [4:0] a, input logic lk);
    case (a)
      5'd0:    return m_bmcr;
      5'd1:    return 16'h7809 | (SUP ? 16'h0040 : 16'h0000) | (lk ? 16'h0004 : 16'h0000);
      5'd2:    return 16'h0022;
      5'd3:    return 16'h1560;
      5'd4:    return m_anar;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic m_write(input logic [4:0] a, input logic [15:0] d);
    if (a == 5'd0) m_bmcr = d[15] ? 16'h3100 : (d & 16'h7100);
    else if (a == 5'd4) m_anar = (d & 16'h3FE0) | 16'h0001;
  endtask

  typedef struct {
    logic  t;
    logic  o;
    string tag;
  } exp_s;
  exp_s sbq[$];

  // Monitor: every MDC rise pops one expectation of the line state the MAC sees
  initial begin
    exp_s e;
    forever begin
      @(posedge mdc);
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow actual=empty required=entry");
      end else begin
        e = sbq.pop_front();
        check({e.tag, "_t"}, {15'd0, mdio_t}, {15'd0, e.t});
        if (e.t == 1'b0) check({e.tag, "_o"}, {15'd0, mdio_o}, {15'd0, e.o});
      end
    end
  end

  // One MDC period: 5 aclk low (data set up), 5 aclk high
  task automatic mdc_bit(input logic drv, input logic val, input logic et, input logic eo,
                         input string tag);
    exp_s e;
    @(negedge aclk);
    mac_oe  = drv;
    mac_val = val;
    repeat (4) @(negedge aclk);
    e.t   = et;
    e.o   = eo;
    e.tag = tag;
    sbq.push_back(e);
    mdc = 1'b1;
    repeat (5) @(negedge aclk);
    mdc = 1'b0;
  endtask

  task automatic frame(input int npre, input logic rd, input logic [4:0] pa,
                       input logic [4:0] ra, input logic [15:0] wd, input int rst_at,
                       input logic flip_lk, input string tag);
    logic        acc, live;
    logic [15:0] rv;
    logic [13:0] hdr;
    acc  = (npre >= 32) || (SUP && m_seen && (npre >= 1));
    live = acc && rd && (pa == 5'd1);
    rv   = m_read(ra, link_up);
    for (int i = 0; i < npre; i++) mdc_bit(1'b1, 1'b1, 1'b1, 1'b0, {tag, "_pre"});
    hdr = {2'b01, (rd ? 2'b10 : 2'b01), pa, ra};
    for (int i = 13; i >= 0; i--)
      mdc_bit(1'b1, hdr[i], 1'b1, 1'b0, $sformatf("%s_h%0d", tag, i));
    if (rd) begin
      if (flip_lk) link_up = ~link_up;
      mdc_bit(1'b0, 1'b1, 1'b1, 1'b0, {tag, "_ta1"});
      mdc_bit(1'b0, 1'b1, ~live, 1'b0, {tag, "_ta2"});
      for (int i = 0; i < 16; i++) begin
        if (i == rst_at) begin
          @(negedge aclk);
          rst = 1'b1;
          @(negedge aclk);
          rst = 1'b0;
          check({tag, "_rst_release"}, {15'd0, mdio_t}, 16'd1);
          m_reset();
          live = 1'b0;
        end
        mdc_bit(1'b0, 1'b1, ~live, rv[15-i], $sformatf("%s_d%0d", tag, 15 - i));
      end
    end else begin
      mdc_bit(1'b1, 1'b1, 1'b1, 1'b0, {tag, "_ta1"});
      mdc_bit(1'b1, 1'b0, 1'b1, 1'b0, {tag, "_ta2"});
      for (int i = 0; i < 16; i++)
        mdc_bit(1'b1, wd[15-i], 1'b1, 1'b0, $sformatf("%s_d%0d", tag, 15 - i));
    end
    if (acc && rst_at < 0) begin
      m_seen = 1'b1;
      if (!rd && pa == 5'd1) m_write(ra, wd);
    end
    mac_oe = 1'b1;
    repeat (6) @(negedge aclk);
    check({tag, "_end_t"}, {15'd0, mdio_t}, 16'd1);
    check({tag, "_pins"}, {12'd0, loopback, speed_100, an_enable, full_duplex},
          {12'd0, m_bmcr[14], m_bmcr[13], m_bmcr[12], m_bmcr[8]});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        rd, flip;
    logic [4:0]  pa, ra;
    logic [15:0] wd;
    m_reset();
    repeat (4) @(negedge aclk);
    check("rst_mdio_t", {15'd0, mdio_t}, 16'd1);
    check("rst_mdio_o", {15'd0, mdio_o}, 16'd0);
    check("rst_pins", {12'd0, loopback, speed_100, an_enable, full_duplex}, 16'h0007);
    rst = 1'b0;
    repeat (3) @(negedge aclk);

    frame(32, 1'b1, 5'd1, 5'd2, 16'h0000, -1, 1'b0, "rd_id1");
    frame(32, 1'b0, 5'd1, 5'd0, 16'h2100, -1, 1'b0, "wr_bmcr");
    frame(32, 1'b1, 5'd1, 5'd0, 16'h0000, -1, 1'b0, "rd_bmcr");
    frame(32, 1'b1, 5'd3, 5'd0, 16'h0000, -1, 1'b0, "rd_badad");
    frame(32, 1'b1, 5'd1, 5'd3, 16'h0000, -1, 1'b0, "rd_id2");
    frame(31, 1'b1, 5'd1, 5'd2, 16'h0000, -1, 1'b0, "pre31");
    frame(32, 1'b0, 5'd1, 5'd0, 16'h4000, -1, 1'b0, "wr_lb");
    frame(32, 1'b0, 5'd1, 5'd0, 16'h8000, -1, 1'b0, "wr_swrst");
    frame(32, 1'b1, 5'd1, 5'd0, 16'h0000, -1, 1'b0, "rd_swrst");
    frame(32, 1'b0, 5'd1, 5'd4, 16'hFFFF, -1, 1'b0, "wr_anar");
    frame(32, 1'b1, 5'd1, 5'd4, 16'h0000, -1, 1'b0, "rd_anar");
    link_up = 1'b1;
    frame(32, 1'b1, 5'd1, 5'd1, 16'h0000, 8, 1'b0, "rd_bmsr_rst");
    frame(32, 1'b1, 5'd1, 5'd1, 16'h0000, -1, 1'b0, "rd_bmsr");

    for (int n = 0; n < 28; n++) begin
      rd      = 1'($urandom_range(0, 1));
      pa      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd1;
      ra      = 5'($urandom_range(0, 7));
      wd      = 16'($urandom);
      link_up = 1'($urandom_range(0, 1));
      flip    = rd && ($urandom_range(0, 2) == 0);
      frame(32 + $urandom_range(0, 3), rd, pa, ra, wd, -1, flip, $sformatf("rnd%0d", n));
    end

    repeat (20) @(negedge aclk);
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_drain actual=%0d required=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdio_phy_responder.md
Name: mdio_phy_responder

Overview:
- PHY-side IEEE 802.3 Clause-22 MDIO management responder, the far end of the MAC's MDC/MDIO master (mdc / md_o / md_t / md_i).
- Provides a minimal PHY register file for a bench PHY model and for on-chip loopback setups where no external PHY exists.
- Decodes read/write frames, drives read data back on the shared MDIO line, and exports BMCR control bits to the RMII datapath.

Parameters:
- PHY_ADDR, 5'd1, PHY address this responder answers to.
- PHY_ID1, 16'h0022, value returned for register 2.
- PHY_ID2, 16'h1560, value returned for register 3.

Ports:
- aclk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- mdc  input  1  management clock from MAC, asynchronous to aclk.
- mdio_i  input  1  resolved MDIO line value.
- mdio_o  output  1  value to drive onto MDIO.
- mdio_t  output  1  tristate enable, 1 = high-Z (released).
- link_up  input  1  link status, reflected live in BMSR bit 2.
- loopback  output  1  BMCR[14].
- speed_100  output  1  BMCR[13].
- an_enable  output  1  BMCR[12].
- full_duplex  output  1  BMCR[8].

Behaviour:
- Interface: one clock (aclk); reset rst is synchronous and active-high.
- Input sampling: mdc and mdio_i pass through 2-FF synchronizers on aclk. A rising MDC edge is detected from synchronized mdc (1 then previous 0). mdio_i is sampled from its synchronized copy on that detect cycle. MDC high and low times must each be at least 4 aclk cycles.
- Reset: mdio_t=1, mdio_o=0, state IDLE, preamble count 0. BMCR=16'h3100, so loopback=0, speed_100=1, an_enable=1, full_duplex=1. ANAR=16'h01E1.
- Frame fields, one bit per detected MDC rise: PRE (>=32 ones), ST=01, OP (10 read, 01 write), PHYAD[4:0] MSB first, REGAD[4:0] MSB first, TA, DATA[15:0] MSB first.
- FSM states: IDLE, ST1, OP, PHYAD, REGAD, TA, RD_DATA, WR_DATA.
- IDLE: a sampled 1 increments the 6-bit preamble count, saturating at 32. A sampled 0 with count==32 goes to ST1; a sampled 0 with count<32 clears the count.
- ST1: expects 1; otherwise go to IDLE.
- OP: collects 2 bits. 00 or 11 goes to IDLE.
- PHYAD, REGAD: a 3-bit field counter selects the bit position. On address mismatch the frame still completes through DATA with mdio_t held at 1; no write and no drive occur.
- Read TA: released during the first TA bit. The cycle after the rise that samples TA bit 1, drive mdio_t=0, mdio_o=0. After each subsequent rise, present the next data bit, D15 down to D0. The cycle after the rise sampling D0, set mdio_t=1 and go to IDLE with the preamble count cleared.
- Write TA: the 2 bits are ignored. After 16 data bits, commit on the cycle following the rise that samples D0, then go to IDLE.
- Register map (16-bit):
  - 0 BMCR: bits 14,13,12,8 are R/W. Writing 1 to bit 15 reloads 16'h3100; the bit reads 0. Bit 9 self-clears and reads 0. All other bits read 0.
  - 1 BMSR: read-only, 16'h7809 | (link_up<<2).
  - 2: PHY_ID1.
  - 3: PHY_ID2.
  - 4 ANAR: bits [13:5] are R/W; bits [4:0] are fixed at 5'b00001; bits 15:14 read 0.
  - 5-31: read 16'h0000; writes ignored.
- Read data is latched into a 16-bit shift register when REGAD completes, so a mid-read link_up change does not corrupt the frame.
- rst asserted mid-frame: same-cycle return to reset values; mdio_t=1 on the next cycle.
- Bus contention is not detected. Any MDC rise while in IDLE with mdio_i=1 counts as preamble.

Optional Feature:
- Macro: MDIO_PREAMBLE_SUPPRESS_EN.
- Defined: after at least one fully decoded frame since reset, IDLE accepts ST after a single preceding 1 (preamble suppression per BMSR bit 6). BMSR then reads 16'h7849 | (link_up<<2).
- Undefined: a 32-one preamble is required on every frame, and BMSR bit 6 reads 0.

Test Plan:
- 32x1 preamble, read PHYAD=1, REGAD=2 -> mdio_t=0 from TA bit 2 for 17 MDC periods; bits 0, then 16'h0022 MSB first; mdio_t=1 afterwards.
- Write reg0 16'h2100, then read reg0 -> 16'h2100; loopback=0, speed_100=1, an_enable=0, full_duplex=1.
- Read with PHYAD=5'd3 -> mdio_t stays 1 for the whole frame; a following valid read of reg3 returns 16'h1560.
- 31-one preamble followed by a read frame -> ignored, mdio_t=1. With MDIO_PREAMBLE_SUPPRESS_EN defined and a prior good frame -> responds.
- Write reg0 16'h8000 after setting 16'h4000 -> reg0 reads 16'h3100; loopback=0.
- Assert rst for 1 cycle during RD_DATA bit D7 of a reg1 read -> mdio_t=1 next cycle; the next full frame reads 16'h780D with link_up=1.
